// File: rtl/ara_pkg.sv
// ara_pkg: shared types for the Ara response join.
//   elen_t             - scalar result word returned to CVA6
//   MaxNrClusters      - largest number of Ara clusters a join may combine
//   resp_join_state_e  - join controller state (COLLECT, EMIT)
package ara_pkg;

    localparam int unsigned ELEN          = 64;
    localparam int unsigned MaxNrClusters = 16;

    typedef logic [ELEN-1:0] elen_t;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } resp_join_state_e;

endpackage

// File: rtl/ara_resp_slot.sv
// ara_resp_slot: one-entry response holding register for a single cluster.
//   clk, rst_n        - clock and asynchronous active-low reset
//   collect           - join controller is collecting; entry may accept
//   clear             - drop the entry (merged response was handed off)
//   valid / ready     - cluster response handshake
//   result .. fflags_valid - incoming response fields
//   full              - entry currently holds a response
//   nxt_*             - entry contents as they will stand after this edge,
//                       so the parent can register the merge without a bubble
module ara_resp_slot
    import ara_pkg::*;
#(
    parameter int unsigned TransIdWidth = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    collect,
    input  logic                    clear,
    input  logic                    valid,
    output logic                    ready,
    input  elen_t                   result,
    input  logic [TransIdWidth-1:0] trans_id,
    input  logic                    exc_valid,
    input  logic [63:0]             exc_cause,
    input  logic [4:0]              fflags,
    input  logic                    fflags_valid,
    output logic                    full,
    output logic                    nxt_full,
    output elen_t                   nxt_result,
    output logic [TransIdWidth-1:0] nxt_trans_id,
    output logic                    nxt_exc_valid,
    output logic [63:0]             nxt_exc_cause,
    output logic [4:0]              nxt_fflags,
    output logic                    nxt_fflags_valid
);

    logic                    full_r;
    elen_t                   result_r;
    logic [TransIdWidth-1:0] trans_id_r;
    logic                    exc_valid_r;
    logic [63:0]             exc_cause_r;
    logic [4:0]              fflags_r;
    logic                    fflags_valid_r;
    logic                    capture_s;

    // Ready depends on the full bit, so a full entry can never be overwritten.
    assign ready     = ~full_r & collect;
    assign capture_s = valid & ready;
    assign full      = full_r;

    assign nxt_full         = full_r | capture_s;
    assign nxt_result       = capture_s ? result       : result_r;
    assign nxt_trans_id     = capture_s ? trans_id     : trans_id_r;
    assign nxt_exc_valid    = capture_s ? exc_valid    : exc_valid_r;
    assign nxt_exc_cause    = capture_s ? exc_cause    : exc_cause_r;
    assign nxt_fflags       = capture_s ? fflags       : fflags_r;
    assign nxt_fflags_valid = capture_s ? fflags_valid : fflags_valid_r;

    // Full bit: set on capture, cleared when the merged response leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
        end else if (clear) begin
            full_r <= 1'b0;
        end else begin
            full_r <= nxt_full;
        end
    end

    // Entry payload, written only on an accepted capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r       <= 64'd0;
            trans_id_r     <= {TransIdWidth{1'b0}};
            exc_valid_r    <= 1'b0;
            exc_cause_r    <= 64'd0;
            fflags_r       <= 5'd0;
            fflags_valid_r <= 1'b0;
        end else if (capture_s) begin
            result_r       <= result;
            trans_id_r     <= trans_id;
            exc_valid_r    <= exc_valid;
            exc_cause_r    <= exc_cause;
            fflags_r       <= fflags;
            fflags_valid_r <= fflags_valid;
        end
    end

endmodule

// File: rtl/ara_resp_join.sv
// ara_resp_join: joins the scalar responses of NrClusters Ara instances into a
// single response toward CVA6.
//   clk_i, rst_ni              - clock, asynchronous active-low reset
//   clus_resp_valid_i/ready_o  - per-cluster response handshake
//   clus_result_i .. clus_fflags_valid_i - per-cluster response fields
//   resp_valid_o/ready_i       - merged response handshake
//   resp_result_o, resp_trans_id_o - taken from cluster 0
//   resp_exc_valid_o/cause_o   - OR of exceptions, lowest-index cause
//   resp_fflags_o/valid_o      - OR of qualified FP flags
//   id_mismatch_o              - one-cycle pulse when trans IDs disagree
//   timeout_o                  - sticky flag: a partial join waited too long
module ara_resp_join
    import ara_pkg::*;
#(
    parameter int unsigned NrClusters    = 4,
    parameter int unsigned TransIdWidth  = 3,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NrClusters-1:0]                   clus_resp_valid_i,
    output logic [NrClusters-1:0]                   clus_resp_ready_o,
    input  elen_t [NrClusters-1:0]                  clus_result_i,
    input  logic [NrClusters-1:0][TransIdWidth-1:0] clus_trans_id_i,
    input  logic [NrClusters-1:0]                   clus_exc_valid_i,
    input  logic [NrClusters-1:0][63:0]             clus_exc_cause_i,
    input  logic [NrClusters-1:0][4:0]              clus_fflags_i,
    input  logic [NrClusters-1:0]                   clus_fflags_valid_i,
    output logic                                    resp_valid_o,
    input  logic                                    resp_ready_i,
    output elen_t                                   resp_result_o,
    output logic [TransIdWidth-1:0]                 resp_trans_id_o,
    output logic                                    resp_exc_valid_o,
    output logic [63:0]                             resp_exc_cause_o,
    output logic [4:0]                              resp_fflags_o,
    output logic                                    resp_fflags_valid_o,
    output logic                                    id_mismatch_o,
    output logic                                    timeout_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

    resp_join_state_e state_r, state_nxt_s;
    logic             join_s;
    logic             clear_s;
    logic             collect_s;

    logic [NrClusters-1:0]                   full_s;
    logic [NrClusters-1:0]                   nxt_full_s;
    elen_t [NrClusters-1:0]                  nxt_result_s;
    logic [NrClusters-1:0][TransIdWidth-1:0] nxt_trans_id_s;
    logic [NrClusters-1:0]                   nxt_exc_valid_s;
    logic [NrClusters-1:0][63:0]             nxt_exc_cause_s;
    logic [NrClusters-1:0][4:0]              nxt_fflags_s;
    logic [NrClusters-1:0]                   nxt_fflags_valid_s;
    logic                                    unused_result_s;

    logic        exc_valid_s;
    logic [63:0] exc_cause_s;
    logic [4:0]  fflags_s;
    logic        fflags_valid_s;
    logic        mismatch_s;

    logic [CntW-1:0] cnt_r, cnt_nxt_s;
    logic            timeout_r;
    logic            mismatch_r;

    elen_t                   result_r;
    logic [TransIdWidth-1:0] trans_id_r;
    logic                    exc_valid_r;
    logic [63:0]             exc_cause_r;
    logic [4:0]              fflags_r;
    logic                    fflags_valid_r;

    assign collect_s = (state_r == COLLECT);

    for (genvar c = 0; c < int'(NrClusters); c++) begin : g_slot
        ara_resp_slot #(
            .TransIdWidth(TransIdWidth)
        ) i_slot (
            .clk              (clk_i),
            .rst_n            (rst_ni),
            .collect          (collect_s),
            .clear            (clear_s),
            .valid            (clus_resp_valid_i[c]),
            .ready            (clus_resp_ready_o[c]),
            .result           (clus_result_i[c]),
            .trans_id         (clus_trans_id_i[c]),
            .exc_valid        (clus_exc_valid_i[c]),
            .exc_cause        (clus_exc_cause_i[c]),
            .fflags           (clus_fflags_i[c]),
            .fflags_valid     (clus_fflags_valid_i[c]),
            .full             (full_s[c]),
            .nxt_full         (nxt_full_s[c]),
            .nxt_result       (nxt_result_s[c]),
            .nxt_trans_id     (nxt_trans_id_s[c]),
            .nxt_exc_valid    (nxt_exc_valid_s[c]),
            .nxt_exc_cause    (nxt_exc_cause_s[c]),
            .nxt_fflags       (nxt_fflags_s[c]),
            .nxt_fflags_valid (nxt_fflags_valid_s[c])
        );
    end

    // Only cluster 0's result reaches CVA6; the other entries are kept but unused.
    assign unused_result_s = ^nxt_result_s;

    // Join controller: the join fires on the edge that fills the last entry,
    // so the merged response is valid one cycle after the final capture.
    always_comb begin
        state_nxt_s = state_r;
        join_s      = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            COLLECT: begin
                if (&nxt_full_s) begin
                    state_nxt_s = EMIT;
                    join_s      = 1'b1;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            EMIT: begin
                if (resp_ready_i) begin
                    state_nxt_s = COLLECT;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            default: begin
                state_nxt_s = COLLECT;
            end
        endcase
    end

    // Merge of the entries as they stand after this edge; the descending scan
    // leaves the lowest-index excepting cluster's cause in place.
    always_comb begin
        exc_valid_s    = 1'b0;
        exc_cause_s    = 64'd0;
        fflags_s       = 5'd0;
        fflags_valid_s = 1'b0;
        mismatch_s     = 1'b0;
        for (int c = int'(NrClusters) - 1; c >= 0; c--) begin
            exc_valid_s    = exc_valid_s | nxt_exc_valid_s[c];
            exc_cause_s    = nxt_exc_valid_s[c] ? nxt_exc_cause_s[c] : exc_cause_s;
            fflags_s       = fflags_s | (nxt_fflags_s[c] & {5{nxt_fflags_valid_s[c]}});
            fflags_valid_s = fflags_valid_s | nxt_fflags_valid_s[c];
            mismatch_s     = mismatch_s | (nxt_trans_id_s[c] != nxt_trans_id_s[0]);
        end
    end

    // Watchdog: counts only while a join is partially filled; saturates.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (join_s) begin
            cnt_nxt_s = {CntW{1'b0}};
        end else if (collect_s && (|full_s) && !(&full_s)) begin
            cnt_nxt_s = (cnt_r == CntMax) ? cnt_r : cnt_r + CntW'(1'b1);
        end else begin
            cnt_nxt_s = {CntW{1'b0}};
        end
    end

    // Controller state, watchdog and the one-cycle mismatch pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= COLLECT;
            cnt_r      <= {CntW{1'b0}};
            timeout_r  <= 1'b0;
            mismatch_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            mismatch_r <= join_s & mismatch_s;
            if (cnt_nxt_s == CntMax) begin
                timeout_r <= 1'b1;
            end
        end
    end

    // Merged response registers, loaded only when the join fires so they
    // stay put for the whole EMIT stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_r       <= 64'd0;
            trans_id_r     <= {TransIdWidth{1'b0}};
            exc_valid_r    <= 1'b0;
            exc_cause_r    <= 64'd0;
            fflags_r       <= 5'd0;
            fflags_valid_r <= 1'b0;
        end else if (join_s) begin
            result_r       <= nxt_result_s[0];
            trans_id_r     <= nxt_trans_id_s[0];
            exc_valid_r    <= exc_valid_s;
            exc_cause_r    <= exc_cause_s;
            fflags_r       <= fflags_s;
            fflags_valid_r <= fflags_valid_s;
        end
    end

    assign resp_valid_o        = (state_r == EMIT);
    assign resp_result_o       = result_r;
    assign resp_trans_id_o     = trans_id_r;
    assign resp_exc_valid_o    = exc_valid_r;
    assign resp_exc_cause_o    = exc_cause_r;
    assign resp_fflags_o       = fflags_r;
    assign resp_fflags_valid_o = fflags_valid_r;
    assign id_mismatch_o       = mismatch_r;
    assign timeout_o           = timeout_r;

endmodule

// File: tb/tb_ara_resp_join.sv
// tb_ara_resp_join: directed self-checking bench for ara_resp_join with four
// clusters and a 16-cycle watchdog.
module tb_ara_resp_join;
    import ara_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned TW = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        clus_valid;
    logic [N-1:0]        clus_ready;
    logic [N-1:0][63:0]  clus_result;
    logic [N-1:0][TW-1:0] clus_tid;
    logic [N-1:0]        clus_exc_v;
    logic [N-1:0][63:0]  clus_cause;
    logic [N-1:0][4:0]   clus_ff;
    logic [N-1:0]        clus_ffv;
    logic                resp_valid;
    logic                resp_ready;
    logic [63:0]         resp_result;
    logic [TW-1:0]       resp_tid;
    logic                resp_exc_v;
    logic [63:0]         resp_cause;
    logic [4:0]          resp_ff;
    logic                resp_ffv;
    logic                id_mismatch;
    logic                timeout;

    int checks = 0;
    int errors = 0;

    ara_resp_join #(
        .NrClusters   (N),
        .TransIdWidth (TW),
        .TimeoutCycles(16)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clus_resp_valid_i  (clus_valid),
        .clus_resp_ready_o  (clus_ready),
        .clus_result_i      (clus_result),
        .clus_trans_id_i    (clus_tid),
        .clus_exc_valid_i   (clus_exc_v),
        .clus_exc_cause_i   (clus_cause),
        .clus_fflags_i      (clus_ff),
        .clus_fflags_valid_i(clus_ffv),
        .resp_valid_o       (resp_valid),
        .resp_ready_i       (resp_ready),
        .resp_result_o      (resp_result),
        .resp_trans_id_o    (resp_tid),
        .resp_exc_valid_o   (resp_exc_v),
        .resp_exc_cause_o   (resp_cause),
        .resp_fflags_o      (resp_ff),
        .resp_fflags_valid_o(resp_ffv),
        .id_mismatch_o      (id_mismatch),
        .timeout_o          (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        clus_valid  = 4'b0000;
        clus_result = {N{64'd0}};
        clus_tid    = {N{3'd0}};
        clus_exc_v  = 4'b0000;
        clus_cause  = {N{64'd0}};
        clus_ff     = {N{5'd0}};
        clus_ffv    = 4'b0000;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        resp_ready = 1'b1;
        clear_inputs();
        #12;
        checks++;
        if ({resp_valid, id_mismatch, timeout, clus_ready} !== {1'b0, 1'b0, 1'b0, 4'b1111}) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp %b",
                     {resp_valid, id_mismatch, timeout, clus_ready}, 7'b0001111);
        end
        checks++;
        if ({resp_result, resp_tid, resp_exc_v, resp_cause, resp_ff, resp_ffv} !== 138'd0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0",
                     {resp_result, resp_tid, resp_exc_v, resp_cause, resp_ff, resp_ffv});
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        clear_inputs();
        clus_result[0] = 64'hAB;
        clus_result[1] = 64'h101;
        clus_result[2] = 64'h102;
        clus_result[3] = 64'h103;
        clus_tid = {3'd3, 3'd3, 3'd3, 3'd3};
        for (int k = 0; k < 10; k++) begin
            case (k)
                0:       clus_valid = 4'b0001;
                2:       clus_valid = 4'b0010;
                5:       clus_valid = 4'b0100;
                9:       clus_valid = 4'b1000;
                default: clus_valid = 4'b0000;
            endcase
            if (k == 9) begin
                checks++;
                if ({resp_valid, clus_ready} !== 5'b0_1000) begin
                    errors++;
                    $display("FAIL basic_partial got %b exp %b", {resp_valid, clus_ready}, 5'b01000);
                end
            end
            step();
        end
        clus_valid = 4'b0000;
        checks++;
        if ({resp_valid, resp_result, resp_tid, id_mismatch} !== {1'b1, 64'hAB, 3'd3, 1'b0}) begin
            errors++;
            $display("FAIL basic_emit got %b %h %0d %b exp 1 ab 3 0",
                     resp_valid, resp_result, resp_tid, id_mismatch);
        end
        step();
        checks++;
        if ({resp_valid, clus_ready} !== 5'b0_1111) begin
            errors++;
            $display("FAIL basic_after got %b exp %b", {resp_valid, clus_ready}, 5'b01111);
        end
    endtask

    task automatic test_exception();
        clear_inputs();
        clus_tid       = {3'd1, 3'd1, 3'd1, 3'd1};
        clus_cause[0]  = 64'h99;
        clus_cause[1]  = 64'h98;
        clus_cause[2]  = 64'h5;
        clus_cause[3]  = 64'h7;
        clus_exc_v     = 4'b1100;
        clus_valid     = 4'b1111;
        step();
        clus_valid = 4'b0000;
        checks++;
        if ({resp_valid, resp_exc_v, resp_cause} !== {1'b1, 1'b1, 64'h5}) begin
            errors++;
            $display("FAIL exc_lowest got %b %b %h exp 1 1 5", resp_valid, resp_exc_v, resp_cause);
        end
        step();
        clus_exc_v = 4'b1000;
        clus_valid = 4'b1111;
        step();
        clus_valid = 4'b0000;
        checks++;
        if ({resp_valid, resp_exc_v, resp_cause} !== {1'b1, 1'b1, 64'h7}) begin
            errors++;
            $display("FAIL exc_top got %b %b %h exp 1 1 7", resp_valid, resp_exc_v, resp_cause);
        end
        step();
        clus_exc_v = 4'b0000;
        clus_valid = 4'b1111;
        step();
        clus_valid = 4'b0000;
        checks++;
        if ({resp_valid, resp_exc_v, resp_cause} !== {1'b1, 1'b0, 64'h0}) begin
            errors++;
            $display("FAIL exc_none got %b %b %h exp 1 0 0", resp_valid, resp_exc_v, resp_cause);
        end
        step();
    endtask

    task automatic test_backpressure();
        clear_inputs();
        resp_ready     = 1'b0;
        clus_result[0] = 64'h1234;
        clus_tid       = {3'd5, 3'd5, 3'd5, 3'd5};
        clus_exc_v     = 4'b0010;
        clus_cause[1]  = 64'h2A;
        clus_valid     = 4'b1111;
        step();
        // New join offered during the stall must not be taken.
        clear_inputs();
        clus_result[0] = 64'h5555;
        clus_tid       = {3'd6, 3'd6, 3'd6, 3'd6};
        clus_valid     = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({resp_valid, resp_result, resp_tid, resp_exc_v, resp_cause, resp_ff, resp_ffv, clus_ready}
                !== {1'b1, 64'h1234, 3'd5, 1'b1, 64'h2A, 5'd0, 1'b0, 4'b0000}) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got %b %h %0d %b %h ready %b exp 1 1234 5 1 2a ready 0000",
                         i, resp_valid, resp_result, resp_tid, resp_exc_v, resp_cause, clus_ready);
            end
            step();
        end
        resp_ready = 1'b1;
        step();
        checks++;
        if ({resp_valid, clus_ready} !== 5'b0_1111) begin
            errors++;
            $display("FAIL stall_release got %b exp %b", {resp_valid, clus_ready}, 5'b01111);
        end
        step();
        clus_valid = 4'b0000;
        checks++;
        if ({resp_valid, resp_result, resp_tid, resp_exc_v} !== {1'b1, 64'h5555, 3'd6, 1'b0}) begin
            errors++;
            $display("FAIL stall_next got %b %h %0d %b exp 1 5555 6 0",
                     resp_valid, resp_result, resp_tid, resp_exc_v);
        end
        step();
    endtask

    task automatic test_fflags();
        clear_inputs();
        clus_ff    = {5'h02, 5'h10, 5'h04, 5'h01};
        clus_ffv   = 4'b1011;
        clus_valid = 4'b1111;
        step();
        clus_valid = 4'b0000;
        checks++;
        if ({resp_valid, resp_ff, resp_ffv} !== {1'b1, 5'h07, 1'b1}) begin
            errors++;
            $display("FAIL fflags_or got %b %h %b exp 1 07 1", resp_valid, resp_ff, resp_ffv);
        end
        step();
        clus_ff    = {5'h1F, 5'h1F, 5'h1F, 5'h1F};
        clus_ffv   = 4'b0000;
        clus_valid = 4'b1111;
        step();
        clus_valid = 4'b0000;
        checks++;
        if ({resp_valid, resp_ff, resp_ffv} !== {1'b1, 5'h00, 1'b0}) begin
            errors++;
            $display("FAIL fflags_none got %b %h %b exp 1 00 0", resp_valid, resp_ff, resp_ffv);
        end
        step();
    endtask

    task automatic test_timeout_mismatch();
        clear_inputs();
        clus_result[0] = 64'h42;
        clus_tid       = {3'd4, 3'd4, 3'd3, 3'd3};
        clus_valid     = 4'b0011;
        step();
        clus_valid = 4'b0000;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        checks++;
        if ({timeout, resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_early got %b exp 00", {timeout, resp_valid});
        end
        step();
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rise got %b exp 1", timeout);
        end
        clus_valid = 4'b1100;
        step();
        clus_valid = 4'b0000;
        checks++;
        if ({resp_valid, id_mismatch, resp_tid, resp_result} !== {1'b1, 1'b1, 3'd3, 64'h42}) begin
            errors++;
            $display("FAIL mismatch_pulse got %b %b %0d %h exp 1 1 3 42",
                     resp_valid, id_mismatch, resp_tid, resp_result);
        end
        step();
        checks++;
        if ({resp_valid, id_mismatch, timeout} !== 3'b001) begin
            errors++;
            $display("FAIL mismatch_end got %b exp 001", {resp_valid, id_mismatch, timeout});
        end
    endtask

    task automatic test_reset_midjoin();
        clear_inputs();
        clus_valid = 4'b0111;
        step();
        clus_valid = 4'b0000;
        checks++;
        if (clus_ready !== 4'b1000) begin
            errors++;
            $display("FAIL midjoin_fill got %b exp 1000", clus_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({resp_valid, id_mismatch, timeout, clus_ready} !== {1'b0, 1'b0, 1'b0, 4'b1111}) begin
            errors++;
            $display("FAIL midjoin_ctrl got %b exp %b",
                     {resp_valid, id_mismatch, timeout, clus_ready}, 7'b0001111);
        end
        checks++;
        if ({resp_result, resp_tid, resp_exc_v, resp_cause, resp_ff, resp_ffv} !== 138'd0) begin
            errors++;
            $display("FAIL midjoin_data got %h exp 0",
                     {resp_result, resp_tid, resp_exc_v, resp_cause, resp_ff, resp_ffv});
        end
        step();
        step();
        rst_n = 1'b1;
        clus_result[0] = 64'h77;
        clus_tid       = {3'd2, 3'd2, 3'd2, 3'd2};
        clus_valid     = 4'b1111;
        step();
        clus_valid = 4'b0000;
        checks++;
        if ({resp_valid, resp_result, resp_tid, id_mismatch} !== {1'b1, 64'h77, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL fresh_join got %b %h %0d %b exp 1 77 2 0",
                     resp_valid, resp_result, resp_tid, id_mismatch);
        end
        step();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fresh_once got %b exp 0", resp_valid);
        end
        step();
        checks++;
        if ({resp_valid, clus_ready} !== 5'b0_1111) begin
            errors++;
            $display("FAIL fresh_idle got %b exp %b", {resp_valid, clus_ready}, 5'b01111);
        end
    endtask

    // Test sequence and final summary.
    initial begin
        test_reset();
        test_basic();
        test_exception();
        test_backpressure();
        test_fflags();
        test_timeout_mismatch();
        test_reset_midjoin();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
